// File: rtl/traffic_pkg.sv
// Shared phase encoding and default timing for the intersection phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_G1    = 3'd0,
    PH_Y1    = 3'd1,
    PH_G2    = 3'd2,
    PH_Y2    = 3'd3,
    PH_PED   = 3'd4,
    PH_FLASH = 3'd5
  } phase_t;

  localparam int DEF_CLK_PER_TICK = 50_000_000;
  localparam int DEF_T_GREEN      = 15;
  localparam int DEF_T_YEL        = 5;
  localparam int DEF_T_PED        = 10;

  // Timer load value for a phase lasting d ticks.
  function automatic logic [7:0] dur_m1(input int d);
    return 8'(d - 1);
  endfunction

endpackage

// File: rtl/traffic_phase_sched_tick_prescaler.sv
// Divides clk down to a one-cycle timing tick every CLK_PER_TICK cycles.
module tick_prescaler #(
  parameter int CLK_PER_TICK = 50_000_000
) (
  input  logic clk,
  input  logic rs,
  output logic tick
);

  localparam int CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0] count_r;

  assign tick = (count_r == LAST);

  // Free-running count, wrapping on the tick cycle.
  always_ff @(posedge clk) begin
    if (rs) begin
      count_r <= '0;
    end else if (tick) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-direction intersection scheduler: green/yellow/red sequencing, pedestrian
// all-red walk insertion, night flashing-yellow mode and countdown displays.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int CLK_PER_TICK = DEF_CLK_PER_TICK,
  parameter int T_GREEN      = DEF_T_GREEN,
  parameter int T_YEL        = DEF_T_YEL,
  parameter int T_PED        = DEF_T_PED
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       ped_req,
  input  logic       night,
  output logic       ped_ack,
  output logic       walk,
  output logic       X1,
  output logic       V1,
  output logic       D1,
  output logic       X2,
  output logic       V2,
  output logic       D2,
  output logic [7:0] counter1,
  output logic [7:0] counter2,
  output logic [2:0] phase
);

  if (CLK_PER_TICK < 1 || T_GREEN < 1 || T_YEL < 1 || T_PED < 1 ||
      T_GREEN + T_YEL > 255 || T_PED > 255) begin : g_param_check
    $error("traffic_phase_sched: timing parameters out of range");
  end

  localparam logic [7:0] TG_M1 = dur_m1(T_GREEN);
  localparam logic [7:0] TY_M1 = dur_m1(T_YEL);
  localparam logic [7:0] TP_M1 = dur_m1(T_PED);
  localparam logic [7:0] TY_8  = 8'(T_YEL);

  logic       tick_s;
  phase_t     phase_r, phase_n, ret_r, ret_n;
  logic [7:0] timer_r, timer_n, disp_s;
  logic       blink_r, blink_n, pend_r, pend_n, ack_r, ack_n, enter_ped_s;

  tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_prescaler (
    .clk  (clk),
    .rs   (rs),
    .tick (tick_s)
  );

  // Scheduler state register.
  always_ff @(posedge clk) begin
    if (rs) begin
      phase_r <= PH_G1;
      timer_r <= TG_M1;
      blink_r <= 1'b0;
      pend_r  <= 1'b0;
      ret_r   <= PH_G1;
      ack_r   <= 1'b0;
    end else begin
      phase_r <= phase_n;
      timer_r <= timer_n;
      blink_r <= blink_n;
      pend_r  <= pend_n;
      ret_r   <= ret_n;
      ack_r   <= ack_n;
    end
  end

  // Next-state logic: a phase ends on the tick that finds its timer at zero.
  always_comb begin
    phase_n     = phase_r;
    timer_n     = timer_r;
    blink_n     = blink_r;
    ret_n       = ret_r;
    ack_n       = 1'b0;
    enter_ped_s = 1'b0;
    case (phase_r)
      PH_FLASH: begin
        if (tick_s && !night) begin
          phase_n = PH_G1;
          timer_n = TG_M1;
          blink_n = 1'b0;
        end else if (tick_s) begin
          blink_n = ~blink_r;
        end else begin
          blink_n = blink_r;
        end
      end
      PH_G1, PH_Y1, PH_G2, PH_Y2, PH_PED: begin
        if (tick_s && timer_r != 8'd0) begin
          timer_n = timer_r - 8'd1;
        end else if (tick_s) begin
          case (phase_r)
            PH_G1: begin
              phase_n = PH_Y1;
              timer_n = TY_M1;
            end
            PH_G2: begin
              phase_n = PH_Y2;
              timer_n = TY_M1;
            end
            PH_PED: begin
              phase_n = ret_r;
              timer_n = TG_M1;
            end
            default: begin
              // End of a yellow: night beats a waiting pedestrian.
              if (night) begin
                phase_n = PH_FLASH;
                timer_n = 8'd0;
                blink_n = 1'b1;
              end else if (pend_r) begin
                phase_n     = PH_PED;
                timer_n     = TP_M1;
                ret_n       = (phase_r == PH_Y1) ? PH_G2 : PH_G1;
                ack_n       = 1'b1;
                enter_ped_s = 1'b1;
              end else begin
                phase_n = (phase_r == PH_Y1) ? PH_G2 : PH_G1;
                timer_n = TG_M1;
              end
            end
          endcase
        end else begin
          timer_n = timer_r;
        end
      end
      default: begin
        phase_n = PH_G1;
        timer_n = TG_M1;
        blink_n = 1'b0;
      end
    endcase

    if (enter_ped_s) begin
      pend_n = 1'b0;
    end else if (ped_req && phase_r != PH_PED) begin
      pend_n = 1'b1;
    end else begin
      pend_n = pend_r;
    end
  end

  // Light and display decode from the phase register.
  always_comb begin
    {X1, V1, D1, X2, V2, D2} = 6'b000_000;
    disp_s = 8'd0;
    case (phase_r)
      PH_G1:    begin {X1, D2} = 2'b11; disp_s = timer_r + 8'd1 + TY_8; end
      PH_Y1:    begin {V1, D2} = 2'b11; disp_s = timer_r + 8'd1; end
      PH_G2:    begin {D1, X2} = 2'b11; disp_s = timer_r + 8'd1 + TY_8; end
      PH_Y2:    begin {D1, V2} = 2'b11; disp_s = timer_r + 8'd1; end
      PH_PED:   begin {D1, D2} = 2'b11; disp_s = timer_r + 8'd1; end
      PH_FLASH: begin V1 = blink_r; V2 = blink_r; disp_s = 8'd0; end
      default:  begin {D1, D2} = 2'b11; disp_s = 8'd0; end
    endcase
  end

  assign walk     = (phase_r == PH_PED);
  assign ped_ack  = ack_r;
  assign counter1 = disp_s;
  assign counter2 = disp_s;
  assign phase    = phase_r;

endmodule
